s_segment: RTL and testbench

// - Registered BCD/hex to seven-segment decoder for a single display digit.
// - Converts a 4-bit value on data into segment drives a..g on y.
// - Sits between the numeric datapath and the display pin drivers.
// - Output is registered so the pins are glitch-free.

---
 rtl/s_segment.sv | 66 ++++++
 tb/tb_s_segment.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/s_segment.sv
// s_segment: registered hex/BCD to seven-segment decoder for one display digit.
// y[6..0] = segments a..g. By default a 1 lights a segment.
// HEX_EN=1 shows A,b,C,d,E,F for codes 10-15. HEX_EN=0 blanks those codes.
// Optional macro SSEG_ACTIVE_LOW_EN inverts every output bit for common-anode
// displays. This also inverts the reset and blank values.
module s_segment #(
    parameter bit HEX_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data,
    input  logic       blank,
    output logic [6:0] y
);

`ifdef SSEG_ACTIVE_LOW_EN
    localparam logic [6:0] OFF_VALUE = 7'h7F;
`else
    localparam logic [6:0] OFF_VALUE = 7'h00;
`endif

    logic [6:0] decoded;
    logic [6:0] nextY;

    // Table lookup in abcdefg order. Unknown codes fall to the blank pattern.
    always_comb begin
        decoded = 7'h00;
        case (data)
            4'h0: decoded = 7'h7E;
            4'h1: decoded = 7'h30;
            4'h2: decoded = 7'h6D;
            4'h3: decoded = 7'h79;
            4'h4: decoded = 7'h33;
            4'h5: decoded = 7'h5B;
            4'h6: decoded = 7'h5F;
            4'h7: decoded = 7'h70;
            4'h8: decoded = 7'h7F;
            4'h9: decoded = 7'h7B;
            4'hA: decoded = HEX_EN ? 7'h77 : 7'h00;
            4'hB: decoded = HEX_EN ? 7'h1F : 7'h00;
            4'hC: decoded = HEX_EN ? 7'h4E : 7'h00;
            4'hD: decoded = HEX_EN ? 7'h3D : 7'h00;
            4'hE: decoded = HEX_EN ? 7'h4F : 7'h00;
            4'hF: decoded = HEX_EN ? 7'h47 : 7'h00;
            default: decoded = 7'h00;
        endcase
    end

    // Blank overrides the decode. The polarity is applied here, ahead of the flop,
    // so that y stays a direct register output.
    always_comb begin
        nextY = blank ? 7'h00 : decoded;
`ifdef SSEG_ACTIVE_LOW_EN
        nextY = ~nextY;
`endif
    end

    // Output register. Reset has priority and turns every segment off.
    always_ff @(posedge clk) begin
        if (rst)
            y <= OFF_VALUE;
        else
            y <= nextY;
    end

endmodule

// File: tb/tb_s_segment.sv
// tb_s_segment: self-checking bench for s_segment.
// Two instances share the same inputs: one built with HEX_EN=1 and one with HEX_EN=0.
// Every output is compared with a table-driven model of the segment patterns.
// The model also follows SSEG_ACTIVE_LOW_EN, so either build can be checked.
module tb_s_segment;

    logic       clk;
    logic       rst;
    logic [3:0] data;
    logic       blank;
    logic [6:0] yHex;
    logic [6:0] yNoHex;

    int compareCount;
    int mismatchCount;

    logic [6:0] segTable [16];

    s_segment #(.HEX_EN(1'b1)) dutHex (
        .clk(clk), .rst(rst), .data(data), .blank(blank), .y(yHex)
    );

    s_segment #(.HEX_EN(1'b0)) dutNoHex (
        .clk(clk), .rst(rst), .data(data), .blank(blank), .y(yNoHex)
    );

    // Free-running clock with a period of 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Segment pattern for one sampled set of inputs, at the output polarity.
    function automatic logic [6:0] modelSeg(input logic r, input logic b,
                                            input logic [3:0] d, input bit hex);
        logic [6:0] v;
        if (r || b)
            v = 7'h00;
        else if (d > 4'd9 && !hex)
            v = 7'h00;
        else
            v = segTable[d];
`ifdef SSEG_ACTIVE_LOW_EN
        v = ~v;
`endif
        return v;
    endfunction

    // Single point of comparison: count it, report it on mismatch.
    task automatic checkOutput(input string tag, input logic [6:0] observed,
                               input logic [6:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 7'h%02h, expected 7'h%02h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drive one set of inputs away from the edge, let one edge sample them,
    // then check both instances just after that edge.
    task automatic applyStimulus(input logic r, input logic b, input logic [3:0] d,
                                 input string tag);
        logic [6:0] expHex;
        logic [6:0] expNoHex;
        @(negedge clk);
        rst   = r;
        blank = b;
        data  = d;
        @(posedge clk);
        expHex   = modelSeg(r, b, d, 1'b1);
        expNoHex = modelSeg(r, b, d, 1'b0);
        #1;
        checkOutput({tag, "/hex"}, yHex, expHex);
        checkOutput({tag, "/nohex"}, yNoHex, expNoHex);
    endtask

    initial begin
        logic       rr;
        logic       bb;
        logic [3:0] dd;
        compareCount  = 0;
        mismatchCount = 0;
        segTable = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                     7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        rst   = 1'b1;
        blank = 1'b0;
        data  = 4'd8;

        // Reset for two edges with data=8, then release reset.
        applyStimulus(1'b1, 1'b0, 4'd8, "reset0");
        applyStimulus(1'b1, 1'b0, 4'd8, "reset1");
        applyStimulus(1'b0, 1'b0, 4'd8, "release");

        // Sweep every code. The two instances differ only on codes 10-15.
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 1'b0, 4'(i), $sformatf("sweep%0d", i));

        // Blank behaviour and its priority.
        applyStimulus(1'b0, 1'b1, 4'd8, "blankOn");
        applyStimulus(1'b0, 1'b1, 4'd3, "blankHeld");
        applyStimulus(1'b0, 1'b0, 4'd8, "blankOff");
        applyStimulus(1'b1, 1'b1, 4'd8, "rstAndBlank");
        applyStimulus(1'b0, 1'b0, 4'd0, "afterReset0");
        applyStimulus(1'b0, 1'b0, 4'd1, "afterReset1");

        // Toggle data between edges: only the value present at the edge is shown,
        // and y must not follow data in the middle of a cycle.
        @(negedge clk);
        rst = 1'b0; blank = 1'b0; data = 4'd5;
        #2 data = 4'd3;
        #2 data = 4'd5;
        #0 data = 4'd3;
        @(posedge clk);
        #1;
        checkOutput("glitchEdge/hex", yHex, modelSeg(1'b0, 1'b0, 4'd3, 1'b1));
        data = 4'd5;
        #2;
        checkOutput("glitchHold/hex", yHex, modelSeg(1'b0, 1'b0, 4'd3, 1'b1));
        blank = 1'b1;
        #1;
        checkOutput("blankComb/hex", yHex, modelSeg(1'b0, 1'b0, 4'd3, 1'b1));
        @(posedge clk);
        #1;
        checkOutput("glitchNext/hex", yHex, modelSeg(1'b0, 1'b1, 4'd5, 1'b1));

        // Random traffic with occasional reset and blank.
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom_range(0, 19) == 0);
            bb = ($urandom_range(0, 6) == 0);
            dd = 4'($urandom_range(0, 15));
            applyStimulus(rr, bb, dd, $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compareCount, mismatchCount);
        $finish;
    end

endmodule
